data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressed data memory for the RISC-V core with RV32I load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Uses a req/ready handshake with a programmable wait-state counter.
- Detects misaligned and illegal accesses.
- Sits between the execute stage and the writeback mux; the core stalls until `ready`.

Parameters:
- ADDR_WIDTH, 12, byte-address bits used. Memory holds 2^(ADDR_WIDTH-2) 32-bit words.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req  in  1  access request, sampled only in IDLE
- we  in  1  1 = store, 0 = load; sampled with `req`
- funct3  in  3  RV32I size/sign code; sampled with `req`
- addr  in  32  byte address; bits above ADDR_WIDTH-1 ignored (wrap)
- wdata  in  32  store data; low byte/half used for SB/SH
- rdata  out  32  load result, extended per funct3
- ready  out  1  one-cycle response strobe
- err  out  1  valid with `ready`: misaligned or illegal funct3
- busy  out  1  high from acceptance until the `ready` cycle inclusive

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, rdata=0, ready=0, err=0, busy=0.
  - Memory array contents are NOT cleared.
  - Reset mid-operation aborts the access; no write occurs.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If `req`=1: latch we/funct3/addr/wdata, set busy=1, load counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - If `req`=0: stay in IDLE.
- WAIT: decrement counter each cycle; on reaching 0 go to RESP.
- RESP: the single cycle that performs the access.
  - ready=1 for exactly this cycle; then return to IDLE.
  - busy=1 in RESP, 0 on return to IDLE.
- Latency: `ready` is asserted WAIT_CYCLES+1 cycles after the cycle in which `req` is sampled.
- `req` arriving while busy is ignored; it is not queued.
  - `req` held high in the RESP cycle is also ignored.
  - A new access is accepted only in IDLE, the cycle after `ready`.
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW. Any other store code is illegal.
- Alignment rules:
  - Halfword: addr[0] must be 0.
  - Word: addr[1:0] must be 00.
- Error check, in RESP: illegal funct3 or misalignment gives err=1, no write, and rdata unchanged.
- Store, in RESP:
  - Word index = addr[ADDR_WIDTH-1:2].
  - Only the selected byte lanes are updated; other lanes are preserved.
  - SB lane = addr[1:0]; SH lanes = addr[1]*2 +{0,1}.
  - rdata is unchanged on a store.
- Load, in RESP:
  - rdata is registered with the selected byte/half/word.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - rdata holds its value until the next successful load or reset.
- Memory is a synchronous-write array; the read is performed in RESP, so no read-during-write hazard exists within one access.
- Address wrap: addr=2^ADDR_WIDTH+4 accesses the same word as addr=4.
- err=0 whenever ready=0.

Test Plan:
- Reset then idle, WAIT_CYCLES=1: rdata=0, ready=0, busy=0. Hold rst=1 during a pending request: no `ready` and no write.
- SW addr=0x1C wdata=0x00000020, then LW addr=0x1C: `ready` 2 cycles after each req, err=0, rdata=0x00000020.
- SW addr=0x40 wdata=0x11223344; SB addr=0x41 wdata=0xFFFFFF80; LW 0x40 gives 0x11228044; LB 0x41 gives 0xFFFFFF80; LBU 0x41 gives 0x00000080.
- After SW 0x40 0x8001_7FFF: LH 0x40 gives 0x00007FFF; LH 0x42 gives 0xFFFF8001; LHU 0x42 gives 0x00008001.
- LW 0x42, SH 0x43, funct3=011 load, and funct3=100 store: each gives ready=1 with err=1. Memory at 0x40 is unchanged and rdata retains its prior value.
- WAIT_CYCLES=0: `ready` one cycle after req. WAIT_CYCLES=3: `ready` 4 cycles after req, and a second req pulsed during WAIT produces no extra `ready`. Wrap check: a store to 0x1004 (ADDR_WIDTH=12) is read back at 0x004.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressed RV32I data memory with wait states and error detection
module data_memory_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state, state_next;
    logic [3:0]              count, count_next;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             mem [DEPTH];

    // With zero wait states the access happens on the same edge that accepts
    // the request, so the datapath looks at the live inputs while in IDLE.
    logic                    acc_we;
    logic [2:0]              acc_f3;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [31:0]             acc_wdata;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [31:0]             cur_word;
    logic [31:0]             shifted;
    logic                    illegal;
    logic                    misaligned;
    logic                    acc_err;
    logic                    access;
    logic [31:0]             load_val;
    logic [31:0]             store_rep;
    logic [3:0]              byte_en;
    logic [31:0]             merged;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_WIDTH];

    assign acc_we    = (state == S_IDLE) ? we                   : we_q;
    assign acc_f3    = (state == S_IDLE) ? funct3               : funct3_q;
    assign acc_addr  = (state == S_IDLE) ? addr[ADDR_WIDTH-1:0] : addr_q;
    assign acc_wdata = (state == S_IDLE) ? wdata                : wdata_q;
    assign word_idx  = acc_addr[ADDR_WIDTH-1:2];
    assign cur_word  = mem[word_idx];
    assign shifted   = cur_word >> {acc_addr[1:0], 3'b000};

    // The access is performed on the edge that enters RESP, so rdata/err are
    // already valid while ready is high.
    assign access = (state_next == S_RESP) && (state != S_RESP);
    assign ready  = (state == S_RESP);
    assign busy   = (state != S_IDLE);

    // Next-state and wait counter
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            S_IDLE: begin
                if (req) begin
                    count_next = WAIT_INIT;
                    state_next = (WAIT_INIT != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                count_next = count - 4'd1;
                if (count <= 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Legality, alignment, load extension and store lane merge
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        load_val   = 32'd0;
        store_rep  = acc_wdata;
        byte_en    = 4'b0000;
        if (acc_we) begin
            illegal = !(acc_f3 == 3'b000 || acc_f3 == 3'b001 || acc_f3 == 3'b010);
        end else begin
            illegal = !(acc_f3 == 3'b000 || acc_f3 == 3'b001 || acc_f3 == 3'b010 ||
                        acc_f3 == 3'b100 || acc_f3 == 3'b101);
        end
        if (acc_f3[1:0] == 2'b01 && acc_addr[0]) begin
            misaligned = 1'b1;
        end
        if (acc_f3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end
        case (acc_f3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = cur_word;
        endcase
        case (acc_f3[1:0])
            2'b00: begin
                store_rep = {4{acc_wdata[7:0]}};
                byte_en   = 4'b0001 << acc_addr[1:0];
            end
            2'b01: begin
                store_rep = {2{acc_wdata[15:0]}};
                byte_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_rep = acc_wdata;
                byte_en   = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = byte_en[i] ? store_rep[i*8 +: 8] : cur_word[i*8 +: 8];
        end
    end

    assign acc_err = illegal | misaligned;

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Capture the request fields when a new access is accepted
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            we_q     <= we;
            funct3_q <= funct3;
            addr_q   <= addr[ADDR_WIDTH-1:0];
            wdata_q  <= wdata;
        end
    end

    // Response registers: err only for the RESP cycle, rdata only on good loads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            err <= access && acc_err;
            if (access && !acc_err && !acc_we) begin
                rdata <= load_val;
            end
        end
    end

    // Memory write; contents survive reset but a reset edge never writes
    always_ff @(posedge clk) begin
        if (!rst && access && !acc_err && acc_we) begin
            mem[word_idx] <= merged;
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst, req, req0, req3, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata0, rdata3;
    logic        ready, ready0, ready3;
    logic        err, err0, err3;
    logic        busy, busy0, busy3;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[19];

    data_memory_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy));

    data_memory_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0));

    data_memory_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3), .busy(busy3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready of the main DUT pops one expectation
    always @(negedge clk) begin
        if (ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("err", {31'd0, err}, {31'd0, e.err});
                check("rdata", rdata, e.rdata);
                check("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end else if (err) begin
            check("err_without_ready", {31'd0, err}, 32'd0);
        end
    end

    task automatic do_access(input vec_t v);
        exp_t e;
        int   n;
        @(negedge clk);
        we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata; req = 1'b1;
        e.err = v.exp_err; e.rdata = v.exp_rdata; e.issue = cyc; e.lat = 2;
        sb_q.push_back(e);
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Drive one access on dut0 (sel=0) or dut3 (sel=3); optionally pulse a
    // second req during the wait; report latency and number of ready pulses.
    task automatic side_access(input int sel, input logic w, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic extra_req, output int lat, output int nready);
        int t0;
        @(negedge clk);
        we = w; funct3 = f; addr = a; wdata = d;
        if (sel == 0) req0 = 1'b1; else req3 = 1'b1;
        t0 = cyc;
        lat = -1;
        nready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req0 = 1'b0;
            req3 = (extra_req && sel == 3 && i == 1);
            if (sel == 3 && i == 1) check("busy_in_wait", {31'd0, busy3}, 32'd1);
            if ((sel == 0 && ready0) || (sel == 3 && ready3)) begin
                nready++;
                if (lat < 0) lat = cyc - t0;
            end
        end
        req3 = 1'b0;
    endtask

    initial begin
        int lat, nr;
        vecs[0]  = '{1'b1, 3'b010, 32'h1C,   32'h00000020, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 3'b010, 32'h1C,   32'h0,        1'b0, 32'h00000020};
        vecs[2]  = '{1'b1, 3'b010, 32'h40,   32'h11223344, 1'b0, 32'h00000020};
        vecs[3]  = '{1'b1, 3'b000, 32'h41,   32'hFFFFFF80, 1'b0, 32'h00000020};
        vecs[4]  = '{1'b0, 3'b010, 32'h40,   32'h0,        1'b0, 32'h11228044};
        vecs[5]  = '{1'b0, 3'b000, 32'h41,   32'h0,        1'b0, 32'hFFFFFF80};
        vecs[6]  = '{1'b0, 3'b100, 32'h41,   32'h0,        1'b0, 32'h00000080};
        vecs[7]  = '{1'b1, 3'b010, 32'h40,   32'h80017FFF, 1'b0, 32'h00000080};
        vecs[8]  = '{1'b0, 3'b001, 32'h40,   32'h0,        1'b0, 32'h00007FFF};
        vecs[9]  = '{1'b0, 3'b001, 32'h42,   32'h0,        1'b0, 32'hFFFF8001};
        vecs[10] = '{1'b0, 3'b101, 32'h42,   32'h0,        1'b0, 32'h00008001};
        vecs[11] = '{1'b0, 3'b010, 32'h42,   32'h0,        1'b1, 32'h00008001};
        vecs[12] = '{1'b1, 3'b001, 32'h43,   32'hDEAD5555, 1'b1, 32'h00008001};
        vecs[13] = '{1'b0, 3'b011, 32'h40,   32'h0,        1'b1, 32'h00008001};
        vecs[14] = '{1'b1, 3'b100, 32'h40,   32'hDEADBEEF, 1'b1, 32'h00008001};
        vecs[15] = '{1'b0, 3'b010, 32'h40,   32'h0,        1'b0, 32'h80017FFF};
        vecs[16] = '{1'b1, 3'b010, 32'h1004, 32'hAABBCCDD, 1'b0, 32'h80017FFF};
        vecs[17] = '{1'b0, 3'b010, 32'h004,  32'h0,        1'b0, 32'hAABBCCDD};
        vecs[18] = '{1'b0, 3'b010, 32'h80,   32'h0,        1'b0, 32'h12345678};

        rst = 1'b1; req = 1'b0; req0 = 1'b0; req3 = 1'b0;
        we = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);

        // Known value at 0x80, then an access aborted by reset must not write
        do_access('{1'b1, 3'b010, 32'h80, 32'h12345678, 1'b0, 32'h00000000});
        @(negedge clk);
        we = 1'b1; funct3 = 3'b010; addr = 32'h80; wdata = 32'hDEADBEEF; req = 1'b1;
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            do_access(vecs[i]);
        end

        side_access(0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 1'b0, lat, nr);
        check("w0_store_latency", 32'(lat), 32'd1);
        check("w0_store_count", 32'(nr), 32'd1);
        side_access(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, lat, nr);
        check("w0_load_latency", 32'(lat), 32'd1);
        check("w0_load_rdata", rdata0, 32'hCAFEF00D);

        side_access(3, 1'b1, 3'b010, 32'h20, 32'h5A5A5A5A, 1'b1, lat, nr);
        check("w3_store_latency", 32'(lat), 32'd4);
        check("w3_single_ready", 32'(nr), 32'd1);
        side_access(3, 1'b0, 3'b000, 32'h21, 32'h0, 1'b0, lat, nr);
        check("w3_load_latency", 32'(lat), 32'd4);
        check("w3_load_rdata", rdata3, 32'h0000005A);
        check("w3_err", {31'd0, err3}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
